avalon_ram_wait: RTL
====================

Name: avalon_ram_wait

Overview:
Parametrised Avalon-MM slave memory model for CPU test benches, the next generation of the fixed test RAM with an instruction-preload port. Adds configurable depth and base address, programmable or pseudo-random wait states, byte-lane writes, address checking, and access counters. It sits on the CPU's Avalon master bus (address/read/write/waitrequest/byteenable) and also takes a backdoor word-load port that benches use for program preload.

Parameters:
ADDR_W, 10, word-address bits; depth = 2^ADDR_W 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
WAIT_MODE, 0, 0 = fixed wait count, 1 = LFSR-random wait count
WAIT_CYCLES, 2, extra wait cycles N in fixed mode (0..15)
WAIT_MASK, 4'h3, in LFSR mode N = lfsr[3:0] & WAIT_MASK
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
address  in  32  byte address from bus master
read  in  1  read request
write  in  1  write request
byteenable  in  4  write byte lanes; bit i enables writedata[8i+7:8i]
writedata  in  32  write data
readdata  out  32  read data, valid while waitrequest=0 in ACK
waitrequest  out  1  stall; the master holds its request while this is 1
load_en  in  1  backdoor word write enable
load_addr  in  ADDR_W  backdoor word index
load_data  in  32  backdoor data
addr_error  out  1  sticky error flag
rd_count  out  16  completed reads, saturating at 16'hFFFF
wr_count  out  16  completed writes, saturating at 16'hFFFF

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; readdata=0; addr_error=0; rd_count=wr_count=0; lfsr=LFSR_SEED; wait counter=0. Memory array is not cleared; contents are retained across reset.
- waitrequest is combinational: 1 when (read|write) and state!=ACK; otherwise 0.
- FSM:
  - IDLE: on read|write, load counter with N and go to WAIT, or go directly to ACK if N=0. Fixed mode: N=WAIT_CYCLES. LFSR mode: N=lfsr[3:0]&WAIT_MASK, and the LFSR advances once per accepted request (x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0).
  - WAIT: decrement the counter; go to ACK when it reaches 0.
  - ACK: waitrequest=0 and the access completes on the closing clock edge; then go to IDLE.
  - A new request may begin in the cycle after ACK (no back-to-back within ACK).
- Latency: waitrequest is high for exactly N+1 cycles and is low in the (N+2)th cycle of the request.
- readdata is registered on entry to ACK from mem[word index] and holds its value until the next ACK. Reads ignore byteenable.
- Writes update only the enabled lanes at the edge that ends ACK. byteenable=0 makes no change but still counts as a completed write.
- Valid access: address[1:0]==0 and BASE_ADDR <= address < BASE_ADDR + 4*2^ADDR_W. Word index = (address-BASE_ADDR)>>2.
- Invalid access (misaligned, out of range, or read&write both 1):
  - completes with the same latency;
  - memory is unchanged;
  - readdata=0;
  - addr_error is set and stays set until reset;
  - counters do not increment.
- Master drops read/write during WAIT (protocol violation): go to IDLE; no access, no count, no error.
- load_en writes load_data to mem[load_addr] on the clock edge in any state. If it hits the same word in the same edge as a bus write, load_data wins entirely. A same-edge load does not affect readdata registered at that edge, which takes the old value.
- Counters saturate at 16'hFFFF and never wrap.

Test Plan:
- Fixed N=2: write 32'hDEADBEEF to 0x10 with byteenable=4'hF, then read 0x10 -> waitrequest high 3 cycles for each access; readdata=32'hDEADBEEF in ACK; wr_count=1; rd_count=1.
- Preload 32'h11223344 at load_addr 5, then bus write 32'hAABBCCDD to 0x14 with byteenable=4'b0101, then read 0x14 -> readdata=32'h11BB33DD.
- Read 0x1000 (depth 1024, first out-of-range address) and read 0x02 (misaligned) -> each readdata=0, addr_error=1 after the first access, counters unchanged; a subsequent valid access still completes.
- WAIT_MODE=1 with seed 8'hA5 -> per-request waitrequest-high lengths match the reference LFSR sequence masked by 2'b11 for 8 consecutive reads.
- Assert reset low during WAIT of a write to 0x20 -> waitrequest drops immediately, state IDLE, mem[8] unchanged, counters 0; a preloaded word at index 3 reads back intact after reset.
- Same-edge load_en to index 4 with 32'h0 during ACK of a bus write 32'hFFFFFFFF to 0x10 -> mem[4]=32'h0.

Source files
------------

// File: rtl/avalon_ram_wait.sv
// avalon_ram_wait: Avalon-MM slave RAM with wait states, byte lanes, address checking and access counters
module avalon_ram_wait #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_MODE   = 0,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [3:0]  WAIT_MASK   = 4'h3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              addr_error,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_next;
  logic [3:0] cnt, cnt_next, wait_n;
  logic [7:0] lfsr;
  logic [31:0] mem [2**ADDR_W];
  logic [32:0] diff;
  logic [ADDR_W-1:0] idx;
  logic req, valid, done;
  assign req = read | write;
  // The borrow bit of the 33-bit difference flags addresses below the base
  assign diff = {1'b0, address} - {1'b0, BASE_ADDR};
  assign idx = diff[ADDR_W+1:2];
  assign valid = !(read && write) && !diff[32] && (diff[31:0] >> (ADDR_W + 2)) == 32'd0 && diff[1:0] == 2'b00;
  assign wait_n = WAIT_MODE != 0 ? (lfsr[3:0] & WAIT_MASK) : 4'(WAIT_CYCLES);
  assign waitrequest = reset && req && state != ACK;
  assign done = state == ACK && req;
  // Next-state logic: IDLE loads the wait count, WAIT counts it down, ACK completes the access
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (req) begin
        state_next = wait_n == 4'd0 ? ACK : WAIT;
        cnt_next = wait_n;
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        state_next = !req ? IDLE : cnt == 4'd1 ? ACK : WAIT;
      end
      default: state_next = IDLE;
    endcase
  end
  // Control state, wait LFSR, registered read data, sticky error and saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      lfsr <= LFSR_SEED;
      readdata <= 32'd0;
      addr_error <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      if (state == IDLE && req) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (state != ACK && state_next == ACK) readdata <= valid ? mem[idx] : 32'd0;
      if (done && !valid) addr_error <= 1'b1;
      if (done && valid && read) rd_count <= rd_count == 16'hFFFF ? rd_count : rd_count + 16'd1;
      if (done && valid && write) wr_count <= wr_count == 16'hFFFF ? wr_count : wr_count + 16'd1;
    end
  end
  // Memory array is never reset; a same-edge backdoor load overrides the bus write
  always_ff @(posedge clk) begin
    if (done && valid && write)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
    if (load_en) mem[load_addr] <= load_data;
  end
endmodule
